console_text_renderer: RTL and testbench

//  Pipelined text-mode pixel generator for the HDMI path. Maps beam position (cx,cy) to a

---
 rtl/console_pkg.sv | 38 +++
 rtl/attributemap.sv | 18 +
 rtl/console_blink_timer.sv | 26 ++
 rtl/console_text_renderer.sv | 164 ++++++++++++++++
 tb/tb_console_text_renderer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared constants and palette for the text-mode renderer
package console_pkg;

  localparam logic [23:0] BORDER_DEFAULT = 24'h000000;

  // Attribute byte layout: {blink, bg[2:0], fg[3:0]}
  localparam int ATTR_FG_LSB    = 0;
  localparam int ATTR_BG_LSB    = 4;
  localparam int ATTR_BLINK_BIT = 7;

  localparam int PIPE_LAT    = 4;
  localparam int CURSOR_ROWS = 2;

  // 16-entry CGA-style palette
  function automatic logic [23:0] cga_color(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'h0: c = 24'h000000;
      4'h1: c = 24'h0000AA;
      4'h2: c = 24'h00AA00;
      4'h3: c = 24'h00AAAA;
      4'h4: c = 24'hAA0000;
      4'h5: c = 24'hAA00AA;
      4'h6: c = 24'hAA5500;
      4'h7: c = 24'hAAAAAA;
      4'h8: c = 24'h555555;
      4'h9: c = 24'h5555FF;
      4'hA: c = 24'h55FF55;
      4'hB: c = 24'h55FFFF;
      4'hC: c = 24'hFF5555;
      4'hD: c = 24'hFF55FF;
      4'hE: c = 24'hFFFF55;
      default: c = 24'hFFFFFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/attributemap.sv
// rtl/attributemap.sv - combinational attribute byte to fg/bg colour and blink flag
module attributemap
  import console_pkg::*;
(
  input  logic [7:0]  attr,
  output logic [23:0] fg,
  output logic [23:0] bg,
  output logic        blink
);

  // Background only has eight colours; the top attribute bit is reused for blink
  always_comb begin
    fg    = cga_color(attr[ATTR_FG_LSB +: 4]);
    bg    = cga_color({1'b0, attr[ATTR_BG_LSB +: 3]});
    blink = attr[ATTR_BLINK_BIT];
  end

endmodule

// File: rtl/console_blink_timer.sv
// rtl/console_blink_timer.sv - frame counter driving attribute and cursor blink phases
module console_blink_timer #(
  parameter int BLINK_LOG2  = 5,
  parameter int CURSOR_LOG2 = 4
) (
  input  logic clk_pixel,
  input  logic rst_n,
  input  logic frame_tick,
  output logic blink_phase,
  output logic cur_phase
);

  localparam int CNT_W = ((BLINK_LOG2 > CURSOR_LOG2) ? BLINK_LOG2 : CURSOR_LOG2) + 1;

  logic [CNT_W-1:0] cnt;

  // Free-running frame count, advanced once per frame origin pixel
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (frame_tick) cnt <= cnt + CNT_W'(1);
  end

  assign blink_phase = cnt[BLINK_LOG2];
  assign cur_phase   = cnt[CURSOR_LOG2];

endmodule

// File: rtl/console_text_renderer.sv
// rtl/console_text_renderer.sv - four-stage text-mode pixel pipeline with cursor and blink
module console_text_renderer
  import console_pkg::*;
#(
  parameter int          BIT_WIDTH   = 12,
  parameter int          BIT_HEIGHT  = 11,
  parameter int          FONT_WIDTH  = 8,
  parameter int          FONT_HEIGHT = 16,
  parameter int          COLS        = 80,
  parameter int          ROWS        = 30,
  parameter int          BLINK_LOG2  = 5,
  parameter int          CURSOR_LOG2 = 4,
  parameter logic [23:0] BORDER_RGB  = BORDER_DEFAULT
) (
  input  logic                            clk_pixel,
  input  logic                            rst_n,
  input  logic [BIT_WIDTH-1:0]            cx,
  input  logic [BIT_HEIGHT-1:0]           cy,
  input  logic                            cursor_en,
  input  logic [$clog2(COLS)-1:0]         cursor_col,
  input  logic [$clog2(ROWS)-1:0]         cursor_row,
  output logic [$clog2(COLS*ROWS)-1:0]    tram_addr,
  input  logic [15:0]                     tram_data,
  output logic [8+$clog2(FONT_HEIGHT)-1:0] font_addr,
  input  logic [FONT_WIDTH-1:0]           font_data,
  output logic [23:0]                     rgb
);

  localparam int FW_LOG2 = $clog2(FONT_WIDTH);
  localparam int FH_LOG2 = $clog2(FONT_HEIGHT);
  localparam int AW      = $clog2(COLS*ROWS);
  localparam int CW      = BIT_WIDTH - FW_LOG2;
  localparam int RW      = BIT_HEIGHT - FH_LOG2;

  localparam logic [CW-1:0]      COLS_W    = CW'(COLS);
  localparam logic [RW-1:0]      ROWS_W    = RW'(ROWS);
  localparam logic [FH_LOG2-1:0] CUR_START = FH_LOG2'(FONT_HEIGHT - CURSOR_ROWS);
  localparam logic [FW_LOG2-1:0] HMAX      = FW_LOG2'(FONT_WIDTH - 1);

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [FW_LOG2-1:0] hidx;
  logic [FH_LOG2-1:0] vidx;
  logic               inarea, hit, frame_tick;

  logic [FW_LOG2-1:0] s1_hidx, s2a_hidx, s2_hidx, s3_hidx;
  logic [FH_LOG2-1:0] s1_vidx, s2a_vidx;
  logic               s1_in, s2a_in, s2_in, s3_in;
  logic               s1_hit, s2a_hit, s2_hit, s3_hit;
  logic [7:0]         s2_attr, s3_attr;

  logic [23:0] fg, bg, rgb_next;
  logic        blink, blink_phase, cur_phase, pixel;

  // S1 decode: cell coordinates come straight from the beam every pixel
  always_comb begin
    col        = cx[BIT_WIDTH-1:FW_LOG2];
    row        = cy[BIT_HEIGHT-1:FH_LOG2];
    hidx       = cx[FW_LOG2-1:0];
    vidx       = cy[FH_LOG2-1:0];
    inarea     = (col < COLS_W) && (row < ROWS_W);
    hit        = cursor_en && (col == CW'(cursor_col)) && (row == RW'(cursor_row)) &&
                 (vidx >= CUR_START);
    frame_tick = (cx == '0) && (cy == '0);
  end

  // S1 register: text RAM address, parked at 0 outside the text area
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      tram_addr <= '0;
      s1_hidx   <= '0;
      s1_vidx   <= '0;
      s1_in     <= 1'b0;
      s1_hit    <= 1'b0;
    end else begin
      tram_addr <= inarea ? AW'(32'(row) * COLS + 32'(col)) : '0;
      s1_hidx   <= hidx;
      s1_vidx   <= vidx;
      s1_in     <= inarea;
      s1_hit    <= hit;
    end
  end

  // Side-band delay matching the text RAM read cycle
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      s2a_hidx <= '0;
      s2a_vidx <= '0;
      s2a_in   <= 1'b0;
      s2a_hit  <= 1'b0;
    end else begin
      s2a_hidx <= s1_hidx;
      s2a_vidx <= s1_vidx;
      s2a_in   <= s1_in;
      s2a_hit  <= s1_hit;
    end
  end

  // S2 register: font ROM address from codepoint and glyph row; capture attribute
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      font_addr <= '0;
      s2_attr   <= '0;
      s2_hidx   <= '0;
      s2_in     <= 1'b0;
      s2_hit    <= 1'b0;
    end else begin
      font_addr <= {tram_data[7:0], s2a_vidx};
      s2_attr   <= tram_data[15:8];
      s2_hidx   <= s2a_hidx;
      s2_in     <= s2a_in;
      s2_hit    <= s2a_hit;
    end
  end

  // Side-band delay matching the font ROM read cycle
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      s3_attr <= '0;
      s3_hidx <= '0;
      s3_in   <= 1'b0;
      s3_hit  <= 1'b0;
    end else begin
      s3_attr <= s2_attr;
      s3_hidx <= s2_hidx;
      s3_in   <= s2_in;
      s3_hit  <= s2_hit;
    end
  end

  attributemap u_attr (
    .attr  (s3_attr),
    .fg    (fg),
    .bg    (bg),
    .blink (blink)
  );

  console_blink_timer #(
    .BLINK_LOG2  (BLINK_LOG2),
    .CURSOR_LOG2 (CURSOR_LOG2)
  ) u_blink (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .blink_phase (blink_phase),
    .cur_phase   (cur_phase)
  );

  // S3 pixel select and colour priority: border, cursor inversion, blink, glyph
  always_comb begin
    pixel    = font_data[HMAX - s3_hidx];
    rgb_next = pixel ? fg : bg;
    if (!s3_in)                     rgb_next = BORDER_RGB;
    else if (s3_hit && cur_phase)   rgb_next = pixel ? bg : fg;
    else if (blink && blink_phase)  rgb_next = bg;
  end

  // S4 output register
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) rgb <= '0;
    else        rgb <= rgb_next;
  end

endmodule

// File: tb/tb_console_text_renderer.sv
// tb/tb_console_text_renderer.sv - scoreboard bench for console_text_renderer
module tb_console_text_renderer;
  import console_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cx;
  logic [10:0] cy;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] tram_addr;
  logic [15:0] tram_data = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [23:0] rgb;

  logic [15:0] tram_mem [0:4095];
  logic [7:0]  font_mem [0:4095];

  int checks = 0;
  int errors = 0;

  logic [23:0] q_rgb[$];
  logic [11:0] q_tram[$];
  logic [11:0] q_font[$];
  logic        rflag = 1'b0, tflag = 1'b0, fflag = 1'b0;
  logic [PIPE_LAT:0] rpipe = '0;
  logic        tpipe = 1'b0;
  logic [2:0]  fpipe = '0;

  logic        n_en  = 1'b0;
  logic [6:0]  n_col = 7'd3;
  logic [4:0]  n_row = 5'd2;

  console_text_renderer dut (
    .clk_pixel  (clk),
    .rst_n      (rst_n),
    .cx         (cx),
    .cy         (cy),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .tram_addr  (tram_addr),
    .tram_data  (tram_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tram_data <= tram_mem[tram_addr];
    font_data <= font_mem[font_addr];
    rpipe     <= {rpipe[PIPE_LAT-1:0], rflag};
    tpipe     <= tflag;
    fpipe     <= {fpipe[1:0], fflag};
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tpipe) begin
      if (q_tram.size() == 0) check("tram_q_empty", 24'h1, 24'h0);
      else check("tram_addr", 24'(tram_addr), 24'(q_tram.pop_front()));
    end
    if (fpipe[2]) begin
      if (q_font.size() == 0) check("font_q_empty", 24'h1, 24'h0);
      else check("font_addr", 24'(font_addr), 24'(q_font.pop_front()));
    end
    if (rpipe[PIPE_LAT]) begin
      if (q_rgb.size() == 0) check("rgb_q_empty", 24'h1, 24'h0);
      else check("rgb", rgb, q_rgb.pop_front());
    end
  end

  task automatic drive(input int x, input int y,
                       input bit cr, input logic [23:0] er,
                       input bit ct, input logic [11:0] et,
                       input bit cf, input logic [11:0] ef);
    @(negedge clk);
    cx         = 12'(x);
    cy         = 11'(y);
    cursor_en  = n_en;
    cursor_col = n_col;
    cursor_row = n_row;
    rflag = cr; tflag = ct; fflag = cf;
    if (cr) q_rgb.push_back(er);
    if (ct) q_tram.push_back(et);
    if (cf) q_font.push_back(ef);
  endtask

  task automatic px(input int x, input int y, input logic [23:0] er);
    drive(x, y, 1'b1, er, 1'b0, 12'h0, 1'b0, 12'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(700, 0, 1'b0, 24'h0, 1'b0, 12'h0, 1'b0, 12'h0);
  endtask

  task automatic advance(input int frames);
    idle(6);
    for (int i = 0; i < frames; i++) drive(0, 0, 1'b0, 24'h0, 1'b0, 12'h0, 1'b0, 12'h0);
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tram_mem[i] = 16'h0000;
      font_mem[i] = 8'h00;
    end
    tram_mem[0]    = 16'h7F41;
    tram_mem[5]    = 16'h1E42;
    tram_mem[6]    = 16'h9E45;
    tram_mem[162]  = 16'h0741;
    tram_mem[163]  = 16'h2A44;
    tram_mem[2399] = 16'h0C43;
    font_mem[{8'h41, 4'd3}]  = 8'h80;
    font_mem[{8'h42, 4'd0}]  = 8'hA5;
    font_mem[{8'h43, 4'd15}] = 8'h01;
    font_mem[{8'h44, 4'd15}] = 8'hF0;
    font_mem[{8'h44, 4'd14}] = 8'hF0;
    font_mem[{8'h45, 4'd1}]  = 8'hFF;

    rst_n = 1'b0; cx = 12'd700; cy = 11'd0;
    cursor_en = 1'b0; cursor_col = 7'd3; cursor_row = 5'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rgb", rgb, 24'h0);
    check("reset_tram_addr", 24'(tram_addr), 24'h0);
    check("reset_font_addr", 24'(font_addr), 24'h0);
    rst_n = 1'b1;

    // frame count 0: plain glyph rendering and area boundaries
    drive(17, 35, 1'b1, 24'h000000, 1'b1, 12'd162, 1'b1, 12'h413);
    px(16, 35, 24'hAAAAAA);
    px(40, 0, 24'hFFFF55);
    px(41, 0, 24'h0000AA);
    px(42, 0, 24'hFFFF55);
    px(47, 0, 24'hFFFF55);
    drive(640, 35, 1'b1, 24'h000000, 1'b1, 12'd0, 1'b0, 12'h0);
    drive(16, 480, 1'b1, 24'h000000, 1'b1, 12'd0, 1'b0, 12'h0);
    drive(639, 479, 1'b1, 24'hFF5555, 1'b1, 12'd2399, 1'b1, 12'h43F);
    n_en = 1'b1;
    px(24, 47, 24'h55FF55);
    px(28, 47, 24'h00AA00);
    px(48, 1, 24'hFFFF55);

    // frame count 16: cursor phase on
    advance(16);
    px(24, 47, 24'h00AA00);
    px(28, 47, 24'h55FF55);
    px(28, 46, 24'h55FF55);
    px(28, 45, 24'h00AA00);
    px(48, 1, 24'hFFFF55);
    n_col = 7'd4;
    px(24, 47, 24'h55FF55);
    n_col = 7'd3;
    px(24, 47, 24'h00AA00);
    n_en = 1'b0;
    px(28, 47, 24'h00AA00);
    n_en = 1'b1;

    // frame count 32: blink phase on, cursor phase off
    advance(16);
    px(48, 1, 24'h0000AA);
    px(49, 1, 24'h0000AA);
    px(28, 47, 24'h00AA00);
    px(16, 35, 24'hAAAAAA);

    // frame count wraps to 0: blinking glyph visible again
    advance(32);
    px(48, 1, 24'hFFFF55);

    // asynchronous reset mid-frame
    for (int i = 0; i < 6; i++) drive(16, 35, 1'b0, 24'h0, 1'b0, 12'h0, 1'b0, 12'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rgb", rgb, 24'h0);
    check("midreset_tram_addr", 24'(tram_addr), 24'h0);
    check("midreset_font_addr", 24'(font_addr), 24'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(16, 35, 1'b1, 24'hAAAAAA, 1'b1, 12'd162, 1'b0, 12'h0);
    px(48, 1, 24'hFFFF55);
    idle(8);

    check("rgb_queue_drained", 24'(q_rgb.size()), 24'h0);
    check("addr_queue_drained", 24'(q_tram.size() + q_font.size()), 24'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
